// File: rtl/spi_byte_master.sv
// rtl/spi_byte_master.sv - SPI mode-0 byte engine between the flash sequencer and the flash pins
// Paces each byte with spi_flag strobes and returns the received byte on data_read.
module spi_byte_master #(
  parameter int HALF    = 4,
  parameter int CS_IDLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_spi,
  input  logic [7:0] data_write,
  output logic [7:0] data_read,
  output logic       spi_flag,
  output logic       busy,
  output logic       cs_n,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FLAG,
    LATCH,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [7:0] HALF_END  = 8'(HALF - 1);
  localparam logic [7:0] IDLE_LOAD = 8'(CS_IDLE - 1);

  state_t      state;
  logic        en_q;
  logic [7:0]  div;
  logic [7:0]  idle_cnt;
  logic [6:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [2:0]  bit_cnt;
  logic        div_end;

  assign div_end = (div == HALF_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en_q      <= 1'b0;
      div       <= 8'd0;
      idle_cnt  <= 8'd0;
      tx_sh     <= 7'd0;
      rx_sh     <= 8'd0;
      bit_cnt   <= 3'd0;
      data_read <= 8'h00;
      spi_flag  <= 1'b0;
      busy      <= 1'b0;
      cs_n      <= 1'b1;
      sck       <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      en_q <= en_spi;
      case (state)
        IDLE: begin
          if (idle_cnt != 8'd0) begin
            idle_cnt <= idle_cnt - 8'd1;
          end else if (en_q) begin
            cs_n  <= 1'b0;
            busy  <= 1'b1;
            div   <= 8'd0;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            div      <= 8'd0;
            spi_flag <= 1'b1;
            state    <= FLAG;
          end else begin
            div <= div + 8'd1;
          end
        end
        FLAG: begin
          if (div_end) begin
            div      <= 8'd0;
            spi_flag <= 1'b0;
            state    <= LATCH;
          end else begin
            div <= div + 8'd1;
          end
        end
        LATCH: begin
          // Two cycles so an en_spi drop on the flag falling edge reaches en_q.
          if (div == 8'd0) begin
            div <= 8'd1;
          end else begin
            div <= 8'd0;
            if (!en_q) begin
              state <= HOLD;
            end else begin
              tx_sh   <= data_write[6:0];
              mosi    <= data_write[7];
              bit_cnt <= 3'd0;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div <= div + 8'd1;
          end else begin
            div <= 8'd0;
            if (!sck) begin
              sck   <= 1'b1;
              rx_sh <= {rx_sh[6:0], miso};
            end else begin
              sck     <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt != 3'd7) begin
                mosi  <= tx_sh[6];
                tx_sh <= {tx_sh[5:0], 1'b0};
              end else begin
                data_read <= rx_sh;
                spi_flag  <= 1'b1;
                state     <= FLAG;
              end
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            div      <= 8'd0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            idle_cnt <= IDLE_LOAD;
            state    <= IDLE;
          end else begin
            div <= div + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// tb/tb_spi_byte_master.sv - bench for spi_byte_master with a sequencer model and byte-level scoreboard
// Instance 0 runs HALF=4, instance 1 runs HALF=1.
module tb_spi_byte_master;

  localparam int CS_IDLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] seq_bytes [2][4];
  int         seq_len   [2];
  int         drop_bit  [2];
  int         go        [2];
  logic       loopback  [2];
  logic [7:0] miso_pat  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int H = (g == 0) ? 4 : 1;

    logic       en_spi = 1'b0;
    logic [7:0] data_write = 8'h00;
    logic [7:0] data_read;
    logic       spi_flag, busy, cs_n, sck, mosi, miso;

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic [7:0] rx_acc = 8'h00;
    logic [7:0] mosi_log = 8'h00;
    logic [7:0] dr_log [8];
    logic [7:0] cur;
    logic [2:0] idx;
    logic [2:0] pat_idx;
    logic       eb;
    logic       p_sck = 1'b0, p_flag = 1'b0, p_cs = 1'b1, had_txn = 1'b0;
    int bit_i = 0, n_flag = 0, n_sck = 0, sck_total = 0, dr_n = 0;
    int txn_done = 0, txn_flags = 0, txn_scks = 0, txn_started = 0;
    int cs_hi = 0, last_gap = 0, flag_w = 0, sck_w = 0, fall_j = 0, last_flag_w = 0;

    assign pat_idx = 3'(7 - bit_i);
    assign miso = loopback[g] ? mosi : miso_pat[g][pat_idx];

    spi_byte_master #(.HALF(H), .CS_IDLE(CS_IDLE)) dut (
      .clk(clk), .rst_n(rst_n), .en_spi(en_spi), .data_write(data_write),
      .data_read(data_read), .spi_flag(spi_flag), .busy(busy), .cs_n(cs_n),
      .sck(sck), .mosi(mosi), .miso(miso)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        en_spi = 1'b0;
        tx_q.delete();
        rx_q.delete();
        bit_i = 0; rx_acc = 8'h00; txn_started = go[g];
        p_sck = 1'b0; p_flag = 1'b0; p_cs = 1'b1; had_txn = 1'b0;
        flag_w = 0; sck_w = 0; cs_hi = 0;
      end else begin
        check("busy_is_not_cs_n", 32'(busy), 32'(!cs_n));
        if (cs_n) check("sck_low_while_deselected", 32'(sck), 32'd0);
        if (cs_n && !p_cs) begin
          txn_flags = n_flag; txn_scks = n_sck; txn_done++; had_txn = 1'b1;
          check("bytes_left_at_deselect", 32'(tx_q.size()), 32'd0);
          cs_hi = 1;
        end else if (cs_n) begin
          cs_hi++;
        end else if (p_cs) begin
          if (had_txn) check("cs_idle_gap", 32'(cs_hi >= CS_IDLE ? CS_IDLE : cs_hi), 32'(CS_IDLE));
          last_gap = cs_hi; n_flag = 0; n_sck = 0; fall_j = 0; dr_n = 0; mosi_log = 8'h00;
        end

        if (sck && !p_sck) begin
          n_sck++; sck_total++;
          if (bit_i > 0) check("sck_low_width", 32'(sck_w), 32'(H));
          sck_w = 1;
          if (tx_q.size() == 0) begin
            check("sck_without_pending_byte", 32'(tx_q.size()), 32'd1);
          end else begin
            idx = 3'(7 - bit_i);
            cur = tx_q[0];
            eb = cur[idx];
            check("mosi_at_sck_rise", 32'(mosi), 32'(eb));
            mosi_log = {mosi_log[6:0], mosi};
            cur = miso_pat[g];
            rx_acc = {rx_acc[6:0], loopback[g] ? eb : cur[idx]};
            if (drop_bit[g] == bit_i && n_sck == bit_i + 1) en_spi = 1'b0;
            bit_i++;
            if (bit_i == 8) begin
              bit_i = 0;
              rx_q.push_back(rx_acc);
              void'(tx_q.pop_front());
            end
          end
        end else if (!sck && p_sck) begin
          check("sck_high_width", 32'(sck_w), 32'(H));
          sck_w = 1;
        end else begin
          sck_w++;
        end

        if (spi_flag && !p_flag) begin
          n_flag++; flag_w = 1;
          check("flag_on_byte_boundary", 32'(bit_i), 32'd0);
          if (rx_q.size() > 0) check("data_read_at_flag", 32'(data_read), 32'(rx_q.pop_front()));
          if (dr_n < 8) begin dr_log[dr_n] = data_read; dr_n++; end
          data_write = 8'($urandom);
        end else if (!spi_flag && p_flag) begin
          check("flag_width", 32'(flag_w), 32'(H));
          last_flag_w = flag_w;
          fall_j++;
          if (drop_bit[g] < 0) begin
            if (fall_j <= seq_len[g]) begin
              data_write = seq_bytes[g][fall_j - 1];
              tx_q.push_back(data_write);
            end else begin
              en_spi = 1'b0;
            end
          end else if (fall_j == 1) begin
            data_write = seq_bytes[g][0];
            tx_q.push_back(data_write);
          end
        end else if (spi_flag) begin
          flag_w++;
        end

        if (!en_spi && cs_n && txn_started < go[g]) begin
          en_spi = 1'b1; txn_started++; data_write = 8'($urandom);
        end
        p_sck = sck; p_flag = spi_flag; p_cs = cs_n;
      end
    end
  end

  function automatic int get_done(input int g);
    return (g == 0) ? g_dut[0].txn_done : g_dut[1].txn_done;
  endfunction

  task automatic wait_done(input int g, input int target);
    int n = 0;
    while (get_done(g) < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("transaction_completes", 32'(get_done(g) >= target), 32'd1);
  endtask

  task automatic check_idle0(input string tag);
    check({tag, "_cs_n"}, 32'(g_dut[0].cs_n), 32'd1);
    check({tag, "_sck"}, 32'(g_dut[0].sck), 32'd0);
    check({tag, "_mosi"}, 32'(g_dut[0].mosi), 32'd0);
    check({tag, "_spi_flag"}, 32'(g_dut[0].spi_flag), 32'd0);
    check({tag, "_busy"}, 32'(g_dut[0].busy), 32'd0);
    check({tag, "_data_read"}, 32'(g_dut[0].data_read), 32'h00);
  endtask

  initial begin
    int d;
    int s0;
    int n;
    for (int g = 0; g < 2; g++) begin
      go[g] = 0; seq_len[g] = 0; drop_bit[g] = -1; loopback[g] = 1'b1; miso_pat[g] = 8'h00;
      for (int i = 0; i < 4; i++) seq_bytes[g][i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_idle0("reset");
    rst_n = 1'b1;

    // Reset asserted during bit 3 of a byte.
    seq_bytes[0][0] = 8'hC7; seq_len[0] = 1; loopback[0] = 1'b0; miso_pat[0] = 8'hA5;
    go[0] = 1;
    n = 0;
    while (g_dut[0].n_sck < 4 && n < 2000) begin @(negedge clk); n++; end
    check("reached_bit3", 32'(g_dut[0].n_sck >= 4), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_idle0("midshift_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    s0 = g_dut[0].sck_total;
    repeat (40) @(negedge clk);
    check("no_sck_after_reset", 32'(g_dut[0].sck_total - s0), 32'd0);

    // Single byte C7, miso pattern A5.
    d = get_done(0);
    go[0] = 2;
    wait_done(0, d + 1);
    check("single_flags", 32'(g_dut[0].txn_flags), 32'd2);
    check("single_scks", 32'(g_dut[0].txn_scks), 32'd8);
    check("single_mosi_bits", 32'(g_dut[0].mosi_log), 32'hC7);
    check("single_rx", 32'(g_dut[0].dr_log[1]), 32'hA5);
    check("single_flag_width", 32'(g_dut[0].last_flag_w), 32'd4);
    check("single_cs_n_end", 32'(g_dut[0].cs_n), 32'd1);
    check("single_busy_end", 32'(g_dut[0].busy), 32'd0);

    // Three bytes with loopback.
    seq_bytes[0][0] = 8'h03; seq_bytes[0][1] = 8'h00; seq_bytes[0][2] = 8'h10;
    seq_len[0] = 3; loopback[0] = 1'b1;
    d = get_done(0);
    go[0] = 3;
    wait_done(0, d + 1);
    check("three_flags", 32'(g_dut[0].txn_flags), 32'd4);
    check("three_scks", 32'(g_dut[0].txn_scks), 32'd24);
    check("three_rx0", 32'(g_dut[0].dr_log[1]), 32'h03);
    check("three_rx1", 32'(g_dut[0].dr_log[2]), 32'h00);
    check("three_rx2", 32'(g_dut[0].dr_log[3]), 32'h10);

    // en_spi dropped during bit 2 of byte 0.
    seq_bytes[0][0] = 8'h3C; seq_len[0] = 1; drop_bit[0] = 2;
    d = get_done(0);
    go[0] = 4;
    wait_done(0, d + 1);
    check("drop_flags", 32'(g_dut[0].txn_flags), 32'd2);
    check("drop_scks", 32'(g_dut[0].txn_scks), 32'd8);
    check("drop_rx", 32'(g_dut[0].dr_log[1]), 32'h3C);
    s0 = g_dut[0].sck_total;
    repeat (40) @(negedge clk);
    check("drop_no_more_sck", 32'(g_dut[0].sck_total - s0), 32'd0);
    check("drop_cs_n_high", 32'(g_dut[0].cs_n), 32'd1);
    drop_bit[0] = -1;

    // Back-to-back transactions.
    seq_bytes[0][0] = 8'h96; seq_len[0] = 1;
    d = get_done(0);
    go[0] = 6;
    wait_done(0, d + 2);
    check("b2b_gap_min", 32'(g_dut[0].last_gap >= CS_IDLE), 32'd1);
    check("b2b_flags", 32'(g_dut[0].txn_flags), 32'd2);
    check("b2b_rx", 32'(g_dut[0].dr_log[1]), 32'h96);

    // HALF=1 instance.
    seq_bytes[1][0] = 8'h01; seq_len[1] = 1; loopback[1] = 1'b1;
    go[1] = 1;
    wait_done(1, 1);
    check("h1_flags", 32'(g_dut[1].txn_flags), 32'd2);
    check("h1_scks", 32'(g_dut[1].txn_scks), 32'd8);
    check("h1_mosi_bits", 32'(g_dut[1].mosi_log), 32'h01);
    check("h1_rx", 32'(g_dut[1].dr_log[1]), 32'h01);
    check("h1_flag_width", 32'(g_dut[1].last_flag_w), 32'd1);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
